reg_dump_reader: RTL and testbench
==================================

Name: reg_dump_reader

Overview:
- Read-side companion to the register file: on request, walks a range of architectural registers through the file's two read ports.
- Streams each (address, value) pair out over a valid/ready interface to the board I/O and debug path.
- Sits beside the decode-stage readers and muxes onto readReg1/readReg2 only while busy; arbitration happens outside this block.

Parameters:
- ADDR_W, 5: register address width.
- DATA_W, 32: register data width.

Ports:
- clock_in  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request pulse; sampled only in IDLE.
- abort  in  1  synchronous cancel of a dump in progress.
- first_reg  in  ADDR_W  first register to dump; latched on start.
- last_reg  in  ADDR_W  last register to dump; latched on start.
- readReg1  out  ADDR_W  read address to register-file port 1.
- readReg2  out  ADDR_W  read address to register-file port 2.
- readData1  in  DATA_W  register-file port 1 data, combinational from readReg1.
- readData2  in  DATA_W  register-file port 2 data, combinational from readReg2.
- dump_valid  out  1  output beat valid.
- dump_ready  in  1  consumer accepts the beat.
- dump_addr  out  ADDR_W  register index of the current beat.
- dump_data  out  DATA_W  register value of the current beat.
- busy  out  1  high outside IDLE.
- done  out  1  one-cycle pulse after the last beat is accepted.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE.
  - All outputs 0: readReg1/2, dump_valid, dump_addr, dump_data, busy, done.
  - Internal cur, end, buf0/1, has2 cleared.
  - Reset asserted mid-dump drops any pending beat immediately; done is not pulsed.
- States: IDLE, FETCH, DRAIN0, DRAIN1, DONE.
- IDLE:
  - readReg1/2 = 0.
  - On start: cur<=first_reg, end<=last_reg, go to FETCH.
  - start in any other state is ignored.
- FETCH (exactly one cycle):
  - readReg1=cur, readReg2=cur+1 (mod 2^ADDR_W).
  - At the clock edge: buf0<=readData1, buf1<=readData2, has2<=(cur!=end). Go to DRAIN0.
- DRAIN0:
  - dump_valid=1, dump_addr=cur, dump_data=buf0.
  - On dump_valid&&dump_ready: if has2, go to DRAIN1; else go to DONE.
- DRAIN1:
  - dump_valid=1, dump_addr=cur+1, dump_data=buf1.
  - On handshake: if cur+1==end, go to DONE; else cur<=cur+2 and go to FETCH.
- DONE:
  - done=1 for one cycle, busy=1, then go to IDLE.
- Handshake rules:
  - While dump_valid=1 and dump_ready=0, dump_addr and dump_data are held stable.
  - dump_valid never drops without a handshake, except on abort or reset.
- Range:
  - Beat count = ((last_reg - first_reg) mod 2^ADDR_W) + 1.
  - last_reg < first_reg wraps through 31 -> 0.
  - first_reg == last_reg gives exactly one beat.
  - A full 0..31 dump gives 32 beats.
- Latency:
  - start sampled at edge k; FETCH is cycle k+1; first dump_valid in cycle k+2.
  - With dump_ready tied high: 3 cycles per register pair.
  - Full 32-register dump: start to done pulse = 16*3+1 cycles after the start edge.
- Abort:
  - Takes effect in any non-IDLE state: next state is IDLE, dump_valid=0, no done.
  - abort coincident with a handshake: the beat counts as delivered, then go to IDLE.
  - abort has priority over the DONE transition.
- Coherence: values are sampled in the FETCH cycle only. A write to the register file during a dump is visible only for registers not yet fetched; no snapshot guarantee.
- Register 0 is read through the port like any other register (the file returns 0).

Decomposition:
- Shared package: state enum (IDLE, FETCH, DRAIN0, DRAIN1, DONE) and the REG_ADDR_W=5 / REG_DATA_W=32 constants, also used by the register file.
- No sub-module needed; single FSM with the datapath in one module.

Test Plan:
- Full dump: register file preloaded with reg[i]=i*3 (reg0=0), first=0, last=31, dump_ready=1 -> 32 beats, addr 0..31, data 0,3,...,93; done exactly 49 cycles after the start edge; busy low the cycle after done.
- Backpressure: first=1, last=2, reg1=255, reg2=233; dump_ready low for 4 cycles on each beat -> beats (1,255) then (2,233), data stable while stalled, no extra beats.
- Single/odd range: first=last=5 -> one beat (5,reg5) and readReg2 never consumed. first=3, last=7 -> 5 beats, last beat taken from DRAIN0.
- Wrap: first=30, last=1 -> beats with addr 30,31,0,1 in order; beat for addr 0 carries data 0.
- Protocol abuse: start pulsed while busy -> ignored, range unchanged. Write to reg 9 during a 0..31 dump, before 9 is fetched -> the new value appears in the beat for reg 9.
- Abort/reset: abort during DRAIN1 -> dump_valid low next cycle, no done, a new start then works. reset=0 mid-dump -> all outputs 0 asynchronously, state IDLE.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// reg_dump_reader_pkg: register-file geometry and dump FSM states shared with the register file
package reg_dump_reader_pkg;
   localparam int REG_ADDR_W = 5;
   localparam int REG_DATA_W = 32;
   typedef enum logic [2:0] {IDLE, FETCH, DRAIN0, DRAIN1, DONE} dump_state_e;
endpackage

// File: rtl/reg_dump_reader.sv
// reg_dump_reader: walks a register range through the file's two read ports
// and streams (address, value) beats over a valid/ready interface.
module reg_dump_reader
   import reg_dump_reader_pkg::*;
#(
   parameter int ADDR_W = REG_ADDR_W,
   parameter int DATA_W = REG_DATA_W
) (
   input  logic              clock_in,
   input  logic              reset,
   input  logic              start,
   input  logic              abort,
   input  logic [ADDR_W-1:0] first_reg,
   input  logic [ADDR_W-1:0] last_reg,
   output logic [ADDR_W-1:0] readReg1,
   output logic [ADDR_W-1:0] readReg2,
   input  logic [DATA_W-1:0] readData1,
   input  logic [DATA_W-1:0] readData2,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              busy,
   output logic              done
);
   dump_state_e r_state, w_next;
   logic [ADDR_W-1:0] r_cur, r_end, w_cur_p1;
   logic [DATA_W-1:0] r_buf0, r_buf1;
   logic r_has2, w_hs;
   assign w_cur_p1 = r_cur + ADDR_W'(1);
   assign w_hs = dump_valid && dump_ready;
   always_ff @(posedge clock_in or negedge reset)
      if (!reset) r_state <= IDLE;
      else r_state <= w_next;
   always_comb begin
      w_next = r_state;
      if (r_state != IDLE && abort) w_next = IDLE;
      else
         case (r_state)
            IDLE:    w_next = start ? FETCH : IDLE;
            FETCH:   w_next = DRAIN0;
            DRAIN0:  w_next = w_hs ? (r_has2 ? DRAIN1 : DONE) : DRAIN0;
            DRAIN1:  w_next = w_hs ? (w_cur_p1 == r_end ? DONE : FETCH) : DRAIN1;
            default: w_next = IDLE;
         endcase
   end
   // Both read ports are sampled only in FETCH; later writes to those registers are not seen.
   always_ff @(posedge clock_in or negedge reset)
      if (!reset) begin
         r_cur  <= '0;
         r_end  <= '0;
         r_buf0 <= '0;
         r_buf1 <= '0;
         r_has2 <= 1'b0;
      end else begin
         if (r_state == IDLE && start) begin
            r_cur <= first_reg;
            r_end <= last_reg;
         end
         if (r_state == FETCH) begin
            r_buf0 <= readData1;
            r_buf1 <= readData2;
            r_has2 <= r_cur != r_end;
         end
         if (r_state == DRAIN1 && w_next == FETCH) r_cur <= r_cur + ADDR_W'(2);
      end
   always_comb begin
      readReg1   = r_state == FETCH ? r_cur : '0;
      readReg2   = r_state == FETCH ? w_cur_p1 : '0;
      dump_valid = r_state == DRAIN0 || r_state == DRAIN1;
      dump_addr  = r_state == DRAIN0 ? r_cur : r_state == DRAIN1 ? w_cur_p1 : '0;
      dump_data  = r_state == DRAIN0 ? r_buf0 : r_state == DRAIN1 ? r_buf1 : '0;
      busy       = r_state != IDLE;
      done       = r_state == DONE;
   end
endmodule

// File: tb/tb_reg_dump_reader.sv
// tb_reg_dump_reader: register-file model plus beat-queue reference for reg_dump_reader.
module tb_reg_dump_reader;
   import reg_dump_reader_pkg::*;
   localparam int AW = REG_ADDR_W;
   localparam int DW = REG_DATA_W;
   logic clock_in = 1'b0, reset = 1'b0, start = 1'b0, abort = 1'b0, dump_ready = 1'b0;
   logic [AW-1:0] first_reg = '0, last_reg = '0, readReg1, readReg2, dump_addr;
   logic [DW-1:0] readData1, readData2, dump_data;
   logic dump_valid, busy, done;
   logic [DW-1:0] rf [32];
   int checks = 0, failures = 0;
   typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } beat_t;
   beat_t q [$];
   always #5 clock_in = ~clock_in;
   assign readData1 = readReg1 == '0 ? '0 : rf[readReg1];
   assign readData2 = readReg2 == '0 ? '0 : rf[readReg2];
   reg_dump_reader dut (
      .clock_in(clock_in), .reset(reset), .start(start), .abort(abort),
      .first_reg(first_reg), .last_reg(last_reg),
      .readReg1(readReg1), .readReg2(readReg2), .readData1(readData1), .readData2(readData2),
      .dump_valid(dump_valid), .dump_ready(dump_ready), .dump_addr(dump_addr), .dump_data(dump_data),
      .busy(busy), .done(done)
   );
   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   // Expected beats: every register from first to last, wrapping modulo 32.
   task automatic build(input int f, input int l);
      q.delete();
      for (int i = 0; i <= ((l - f) & 31); i++) begin
         int a;
         a = (f + i) & 31;
         q.push_back('{a: AW'(a), d: (a == 0 ? '0 : rf[a])});
      end
   endtask
   // mode 0: ready tied high, 1: random ready, 2: four stall cycles per beat
   task automatic run_dump(input int f, input int l, input int mode, input int done_at,
                           input int abort_at, input int wr_at, input int wr_addr,
                           input logic [DW-1:0] wr_val, input int restart_at);
      int cyc, stall;
      logic fin, pv;
      logic [AW-1:0] pa;
      logic [DW-1:0] pd;
      cyc = 1; stall = 0; fin = 1'b0; pv = 1'b0; pa = '0; pd = '0;
      build(f, l);
      first_reg = AW'(f); last_reg = AW'(l); start = 1'b1;
      @(posedge clock_in);
      #1 start = 1'b0;
      while (!fin && cyc <= 800) begin
         dump_ready = mode == 0 ? 1'b1 : mode == 1 ? 1'($urandom_range(0, 1)) : 1'(stall >= 4);
         abort = cyc == abort_at;
         if (cyc == wr_at) begin
            rf[wr_addr] = wr_val;
            foreach (q[i]) if (q[i].a == AW'(wr_addr)) q[i].d = wr_val;
         end
         if (cyc == restart_at) begin
            start = 1'b1; first_reg = AW'($urandom); last_reg = AW'($urandom);
         end else start = 1'b0;
         #1;
         if (pv) begin
            chk("hold_valid", dump_valid, 1);
            chk("hold_addr", dump_addr, pa);
            chk("hold_data", dump_data, pd);
         end
         pv = dump_valid && !dump_ready; pa = dump_addr; pd = dump_data;
         if (dump_valid && dump_ready) begin
            chk("beat_avail", q.size() > 0, 1);
            if (q.size() > 0) begin
               chk("beat_addr", dump_addr, q[0].a);
               chk("beat_data", dump_data, q[0].d);
               void'(q.pop_front());
            end
            stall = 0;
         end else if (dump_valid) stall++;
         if (abort) begin
            @(posedge clock_in);
            #1 abort = 1'b0; dump_ready = 1'b0;
            #1;
            chk("abort_valid", dump_valid, 0);
            chk("abort_busy", busy, 0);
            repeat (4) begin
               @(posedge clock_in);
               #1 chk("abort_no_done", done, 0);
            end
            fin = 1'b1;
         end else if (done) begin
            chk("done_drained", q.size(), 0);
            if (done_at > 0) chk("done_cycle", cyc, done_at);
            @(posedge clock_in);
            #1 dump_ready = 1'b0;
            chk("busy_after_done", busy, 0);
            chk("done_one_cycle", done, 0);
            fin = 1'b1;
         end else begin
            @(posedge clock_in);
            #1 cyc++;
         end
      end
      chk("dump_finished", fin, 1);
      start = 1'b0; abort = 1'b0; dump_ready = 1'b0;
   endtask
   initial begin
      for (int i = 0; i < 32; i++) rf[i] = DW'(i * 3);
      #12;
      chk("rst_valid", dump_valid, 0);
      chk("rst_busy_done", {busy, done}, 0);
      chk("rst_rr", {readReg1, readReg2}, 0);
      chk("rst_beat", {dump_addr, dump_data}, 0);
      @(posedge clock_in);
      #1 reset = 1'b1;
      @(posedge clock_in);
      #1;
      run_dump(0, 31, 0, 49, 0, 0, 0, '0, 0);
      run_dump(0, 31, 0, 49, 0, 3, 9, 32'hCAFE_0009, 10);
      rf[1] = 32'd255; rf[2] = 32'd233;
      run_dump(1, 2, 2, 0, 0, 0, 0, '0, 0);
      for (int i = 1; i < 32; i++) rf[i] = $urandom;
      run_dump(5, 5, 0, 0, 0, 0, 0, '0, 0);
      run_dump(3, 7, 1, 0, 0, 0, 0, '0, 0);
      run_dump(30, 1, 1, 0, 0, 0, 0, '0, 0);
      repeat (4) begin
         for (int i = 1; i < 32; i++) rf[i] = $urandom;
         run_dump($urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(1, 2), 0, 0, 0, 0, '0, 0);
      end
      run_dump(0, 31, 0, 0, 3, 0, 0, '0, 0);
      run_dump(4, 6, 1, 0, 0, 0, 0, '0, 0);
      // Asynchronous reset while a beat is being presented.
      first_reg = '0; last_reg = 5'd31; start = 1'b1; dump_ready = 1'b1;
      @(posedge clock_in);
      #1 start = 1'b0;
      repeat (4) @(posedge clock_in);
      #1 chk("pre_rst_valid", dump_valid, 1);
      #2 reset = 1'b0;
      #1;
      chk("mid_rst_valid", dump_valid, 0);
      chk("mid_rst_busy_done", {busy, done}, 0);
      chk("mid_rst_rr", {readReg1, readReg2}, 0);
      chk("mid_rst_beat", {dump_addr, dump_data}, 0);
      repeat (2) @(posedge clock_in);
      #1 reset = 1'b1; dump_ready = 1'b0;
      @(posedge clock_in);
      #1 chk("post_rst_idle", busy, 0);
      run_dump(28, 2, 1, 0, 0, 0, 0, '0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
